// File: rtl/reg_bank_wr.sv
// Register bank write/read stage: 16 x 32 register file fed by the registered mux output.
// Latency: write visible 2 cycles after wr_en (control delayed 1 stage to meet mux data); reads 1 cycle.
// Backpressure: none; accepts one write and two reads every cycle. Optional macro: REG_BANK_BYPASS_EN.
module reg_bank_wr #(
  parameter int PA_ADDR = 4,
  parameter int PA_DATA = 32,
  parameter int PA_HL   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [PA_ADDR-1:0] wr_addr,
  input  logic [PA_HL-1:0]   hl_sel,
  input  logic [PA_DATA-1:0] mux_out,
  input  logic [PA_ADDR-1:0] rd_a_addr,
  input  logic [PA_ADDR-1:0] rd_b_addr,
  output logic [PA_DATA-1:0] rd_a_data,
  output logic [PA_DATA-1:0] rd_b_data,
  output logic               hazard_a,
  output logic               hazard_b,
  output logic               wr_done
);

  localparam int DEPTH = 2 ** PA_ADDR;
  localparam int HALF  = PA_DATA / 2;
  localparam logic [PA_HL-1:0] HL_LO   = PA_HL'(1);
  localparam logic [PA_HL-1:0] HL_HI   = PA_HL'(2);
  localparam logic [PA_HL-1:0] HL_NONE = PA_HL'(3);

  logic [PA_DATA-1:0] mem [DEPTH];

  logic               wr_v_q;
  logic [PA_ADDR-1:0] wr_addr_q;
  logic [PA_HL-1:0]   hl_q;

  logic               wr_ok;
  logic [PA_DATA-1:0] old_word;
  logic [PA_DATA-1:0] new_word;
  logic               byp_a;
  logic               byp_b;

  // A write is real only if it targets a non-zero register and is not masked off entirely.
  assign wr_ok    = wr_en & (wr_addr != '0) & (hl_sel != HL_NONE);
  assign hazard_a = wr_ok & (rd_a_addr == wr_addr);
  assign hazard_b = wr_ok & (rd_b_addr == wr_addr);

  // Stage 1: hold the write control one cycle so it lines up with the registered mux data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_v_q    <= 1'b0;
      wr_addr_q <= '0;
      hl_q      <= '0;
      wr_done   <= 1'b0;
    end else begin
      wr_v_q    <= wr_ok;
      wr_addr_q <= wr_addr;
      hl_q      <= hl_sel;
      wr_done   <= wr_v_q;
    end
  end

  // Half-word merge of incoming data onto the current register contents.
  always_comb begin
    old_word = mem[wr_addr_q];
    new_word = mux_out;
    case (hl_q)
      HL_LO:   new_word = {old_word[PA_DATA-1:HALF], mux_out[HALF-1:0]};
      HL_HI:   new_word = {mux_out[PA_DATA-1:HALF], old_word[HALF-1:0]};
      default: new_word = mux_out;
    endcase
  end

  // Stage 2: commit the merged word; mux_out is ignored unless a write is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_v_q) begin
      mem[wr_addr_q] <= new_word;
    end
  end

`ifdef REG_BANK_BYPASS_EN
  // Forward the committing value to a read sampled at the same edge.
  assign byp_a = wr_v_q & (rd_a_addr == wr_addr_q);
  assign byp_b = wr_v_q & (rd_b_addr == wr_addr_q);
`else
  // Without forwarding, a same-edge read sees the pre-commit contents.
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  // Registered read ports; register 0 is never written so it always returns zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_data <= '0;
      rd_b_data <= '0;
    end else begin
      rd_a_data <= byp_a ? new_word : mem[rd_a_addr];
      rd_b_data <= byp_b ? new_word : mem[rd_b_addr];
    end
  end

endmodule
